// File: rtl/waterfall_line_reader.sv
// Captures one spectrum line from the sliding DFT bin port into a line buffer,
// then streams it out as saturated, handshaked pixels with a wrapping row index.
module waterfall_line_reader #(
    parameter  int FREQ_W     = 16,
    parameter  int LIMIT_BINS = 32,
    parameter  int PIX_W      = 8,
    parameter  int SHIFT      = 4,
    parameter  int LINES      = 64,
    localparam int BIN_ADDR_W = $clog2(LIMIT_BINS),
    localparam int ROW_W      = $clog2(LINES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  line_req,
    input  logic                  sdft_ready,
    output logic                  sdft_read,
    output logic [BIN_ADDR_W-1:0] sdft_bin_addr,
    input  logic [FREQ_W-1:0]     sdft_bin_out,
    output logic [PIX_W-1:0]      pix_data,
    output logic [BIN_ADDR_W-1:0] pix_x,
    output logic [ROW_W-1:0]      pix_y,
    output logic                  pix_valid,
    output logic                  pix_last,
    input  logic                  pix_ready,
    output logic                  busy,
    output logic                  overrun
);
    typedef enum logic [1:0] {IDLE, REQ, SWEEP, SEND} state_t;

    localparam int CNT_W = BIN_ADDR_W + 2;
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(LIMIT_BINS - 1);
    localparam logic [CNT_W-1:0] CAP_END   = CNT_W'(LIMIT_BINS + 1);

    state_t                  state_q, state_d;
    logic                    read_q, read_d;
    logic [BIN_ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    pend_q, pend_d;
    logic                    ovr_q, ovr_d;
    logic [PIX_W-1:0]        pix_data_q, pix_data_d;
    logic [BIN_ADDR_W-1:0]   pix_x_q, pix_x_d;
    logic [ROW_W-1:0]        pix_y_q, pix_y_d;
    logic                    pix_valid_q, pix_valid_d;
    logic                    pix_last_q, pix_last_d;

    logic [FREQ_W-1:0]       line_buf [LIMIT_BINS];
    logic                    buf_we;
    logic [BIN_ADDR_W-1:0]   buf_wa;
    logic [BIN_ADDR_W-1:0]   rd_idx;
    logic [FREQ_W-1:0]       rd_data;

    function automatic logic [PIX_W-1:0] scale(input logic [FREQ_W-1:0] mag);
        logic [FREQ_W-1:0] s;
        s = mag >> SHIFT;
        if (|(s >> PIX_W)) return '1;
        return s[PIX_W-1:0];
    endfunction

    assign rd_data = line_buf[rd_idx];
    // bin k shows up on sdft_bin_out two cycles after its address was presented
    assign buf_wa  = BIN_ADDR_W'(cnt_q - CNT_W'(2));

    always_comb begin
        state_d     = state_q;
        read_d      = read_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        ovr_d       = ovr_q;
        pix_data_d  = pix_data_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_valid_d = pix_valid_q;
        pix_last_d  = pix_last_q;
        buf_we      = 1'b0;
        rd_idx      = pix_x_q + 1'b1;

        if (line_req && state_q != IDLE) begin
            if (pend_q) ovr_d  = 1'b1;
            else        pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (line_req || pend_q) begin
                    state_d = REQ;
                    read_d  = 1'b1;
                    addr_d  = '0;
                    pend_d  = 1'b0;
                end
            end
            REQ: begin
                if (sdft_ready) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                cnt_d  = cnt_q + 1'b1;
                addr_d = (cnt_q < LAST_ADDR) ? addr_q + 1'b1 : '0;
                if (cnt_q == LAST_ADDR) read_d = 1'b0;
                buf_we = (cnt_q >= CNT_W'(2));
                if (cnt_q == CAP_END) begin
                    // buf[0] landed long ago, so it can be read while the last bin is written
                    state_d     = SEND;
                    rd_idx      = '0;
                    pix_data_d  = scale(rd_data);
                    pix_x_d     = '0;
                    pix_valid_d = 1'b1;
                    pix_last_d  = (LIMIT_BINS == 1);
                end
            end
            SEND: begin
                if (pix_valid_q && pix_ready) begin
                    if (pix_last_q) begin
                        pix_valid_d = 1'b0;
                        pix_last_d  = 1'b0;
                        pix_y_d     = (pix_y_q == ROW_W'(LINES - 1)) ? '0 : pix_y_q + 1'b1;
                        if (pend_q) begin
                            state_d = REQ;
                            read_d  = 1'b1;
                            addr_d  = '0;
                            pend_d  = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        pix_x_d    = pix_x_q + 1'b1;
                        pix_data_d = scale(rd_data);
                        pix_last_d = (pix_x_q == BIN_ADDR_W'(LIMIT_BINS - 2));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            read_q      <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            ovr_q       <= 1'b0;
            pix_data_q  <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            read_q      <= read_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            ovr_q       <= ovr_d;
            pix_data_q  <= pix_data_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_valid_q <= pix_valid_d;
            pix_last_q  <= pix_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) line_buf[buf_wa] <= sdft_bin_out;
    end

    assign sdft_read     = read_q;
    assign sdft_bin_addr = addr_q;
    assign pix_data      = pix_data_q;
    assign pix_x         = pix_x_q;
    assign pix_y         = pix_y_q;
    assign pix_valid     = pix_valid_q;
    assign pix_last      = pix_last_q;
    assign busy          = (state_q != IDLE);
    assign overrun       = ovr_q;
endmodule

// File: doc/waterfall_line_reader.md
# waterfall_line_reader

Reads one complete spectrum line out of the sliding DFT through its `read`/`bin_addr`/`bin_out` port and presents it to the display side as a pixel stream. Each line request produces one handshaked stream of `LIMIT_BINS` pixels. It sits between the `sdft` bin-magnitude interface and the waterfall framebuffer writer. Magnitudes are scaled to pixel intensity with saturation. A wrapping row index is tracked so the framebuffer writer can scroll.

## Interface
- `FREQ_W`, 16, width of `sdft_bin_out` magnitude
- `LIMIT_BINS`, 32, bins read per line (power of two); `BIN_ADDR_W = $clog2(LIMIT_BINS)`
- `PIX_W`, 8, pixel intensity width
- `SHIFT`, 4, right-shift applied to magnitude before saturation
- `LINES`, 64, waterfall rows; `ROW_W = $clog2(LINES)`
- `clk`  in  1  single clock, all logic rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `line_req`  in  1  one-cycle pulse: capture and send one line
- `sdft_ready`  in  1  sdft idle (its `ready`)
- `sdft_read`  out  1  to sdft `read`
- `sdft_bin_addr`  out  BIN_ADDR_W  to sdft `bin_addr`
- `sdft_bin_out`  in  FREQ_W  from sdft `bin_out`
- `pix_data`  out  PIX_W  scaled intensity
- `pix_x`  out  BIN_ADDR_W  bin/column index of `pix_data`
- `pix_y`  out  ROW_W  current row
- `pix_valid`  out  1  pixel beat valid
- `pix_last`  out  1  high on beat with `pix_x == LIMIT_BINS-1`
- `pix_ready`  in  1  downstream accepts beat
- `busy`  out  1  high in any state other than IDLE
- `overrun`  out  1  sticky: a `line_req` was dropped

## Operation
- States: IDLE, REQ, SWEEP, SEND.
- IDLE: on `line_req` (or a pending request), go to REQ. `sdft_read` is registered high, and `sdft_bin_addr` is 0.
- REQ: hold `sdft_read=1` and `sdft_bin_addr=0`. Define R0 as the first cycle with `sdft_read=1 && sdft_ready=1`; the sdft then enters its read state in R0+1. Go to SWEEP after R0.
- SWEEP:
  - `sdft_bin_addr = k` in cycle R0+1+k, for k = 0..LIMIT_BINS-1.
  - `sdft_read` stays high through cycle R0+LIMIT_BINS and is low from R0+LIMIT_BINS+1.
  - `sdft_bin_out` for bin k is captured into the internal line buffer (LIMIT_BINS × FREQ_W) in cycle R0+3+k. The last capture is in R0+LIMIT_BINS+2.
  - Then go to SEND.
- SEND:
  - Beats x = 0..LIMIT_BINS-1 in order.
  - `pix_data = min(buf[x] >> SHIFT, 2^PIX_W-1)`, registered.
  - A beat transfers when `pix_valid && pix_ready`.
  - After the `pix_last` transfer: `pix_y <= (pix_y == LINES-1) ? 0 : pix_y+1`, then go to IDLE.
- Request queue: one-deep pending flag.
  - `line_req` while `busy` with nothing pending sets pending.
  - `line_req` while pending is already set sets `overrun`, and the request is dropped.
  - Leaving SEND with pending set clears pending and goes directly to REQ.
- While `sdft_read` is high, sdft `start` is blocked. The sample feeder sees `sdft_ready=0` during SWEEP.
- Arithmetic: the shift is logical (magnitude is unsigned). Saturation applies when any bit above PIX_W-1 is set after the shift.

## Timing
- Reset values: `sdft_read=0`, `sdft_bin_addr=0`, `pix_data=0`, `pix_x=0`, `pix_y=0`, `pix_valid=0`, `pix_last=0`, `busy=0`, `overrun=0`. The pending flag is cleared; the line buffer is not reset.
- Reset mid-operation: `sdft_read` drops immediately. The sdft leaves read on its next edge, and no partial line is emitted.
- `line_req` to first `sdft_read=1`: 1 cycle.
- R0 to first `pix_valid`: LIMIT_BINS+3 cycles.
- Pixel rate: one beat per cycle while `pix_ready=1`.
- Stalled beat: `pix_data`, `pix_x`, `pix_last` and `pix_valid` are held stable until transfer.
- `line_req` in the same cycle as the final `pix_last` transfer counts as arriving while busy (sets pending).

## Test plan
- Bins preset so bin k magnitude = 16·k, `pix_ready=1`, one `line_req` -> 32 beats with `pix_data = k`, `pix_x = k`, `pix_last` only at x=31, `pix_y` 0→1 afterwards.
- Saturation: magnitude 0x0123 -> `pix_data=0x12`; 0x1234 -> 0xFF; 0x000F -> 0x00.
- `sdft_ready` low for 10 cycles after `line_req` -> `sdft_read` held, address stays 0, sweep begins at R0. Bench checks `sdft_bin_addr=k` at R0+1+k and `sdft_read=0` at R0+33.
- Random `pix_ready` (50%) -> beats never change while stalled; all 32 are delivered in order with no duplicates.
- Three `line_req` pulses during one SWEEP -> exactly two lines emitted back-to-back, `overrun=1`; after 64 lines `pix_y` wraps 63→0.
- `rst_n` low mid-SWEEP (k=10) -> all outputs take their reset values asynchronously, no beats emitted, and the next `line_req` produces a full correct line.
